gray_cnt_sched: RTL and testbench

- Round-robin scheduler that shares one 8-bit Gray-code counter among N_REQ requesters.
- Each requester asks for a timed interval of LEN clock ticks.
- The scheduler grants the counter, clears it, enables it until the Gray count equals gray(LEN), then pulses done to the owner.
- Sits between the requesting engines and the counter's count_en/count_clr/count/overflow ports.

---
 rtl/gray_cnt_sched.sv | 99 +++++++++
 tb/tb_gray_cnt_sched.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_cnt_sched.sv
// gray_cnt_sched: round-robin arbiter that lends one shared Gray counter to
// requesters for timed intervals and signals completion to the owner.
module gray_cnt_sched #(
  parameter int N_REQ = 4,
  parameter int CW = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*CW-1:0]   len,
  input  logic                  pause,
  output logic [N_REQ-1:0]      grant,
  output logic [N_REQ-1:0]      done,
  output logic                  err,
  output logic                  busy,
  output logic                  cnt_en,
  output logic                  cnt_clr,
  input  logic [CW-1:0]         cnt_count,
  input  logic                  cnt_overflow
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;
  state_t r_state;
  logic [IW-1:0] r_rr, r_id, w_pick, w_next_rr;
  logic [IW:0] w_idx;
  logic [CW-1:0] r_target, w_len;
  logic [N_REQ-1:0] r_grant, r_done;
  logic r_ovf, r_err, r_busy, r_clr;
  logic w_match, w_own_req, w_abort;
  // Descending scan so the last hit wins: that is the first requester at or above r_rr.
  always_comb begin
    w_pick = r_rr;
    w_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_rr} + (IW+1)'(k);
      w_idx = (w_idx >= (IW+1)'(N_REQ)) ? w_idx - (IW+1)'(N_REQ) : w_idx;
      w_pick = req[w_idx[IW-1:0]] ? w_idx[IW-1:0] : w_pick;
    end
  end
  assign w_len = len[int'(w_pick)*CW +: CW];
  assign w_next_rr = (r_id == IW'(N_REQ - 1)) ? '0 : r_id + 1'b1;
  assign w_own_req = req[r_id];
  assign w_match = cnt_count == r_target;
  assign w_abort = (r_state == CLEAR || r_state == RUN) && !w_own_req;
  // Enable is combinational so the counter halts on the very cycle it reaches the target.
  assign cnt_en = (r_state == RUN) && w_own_req && !pause && !w_match;
  assign cnt_clr = r_clr;
  assign grant = r_grant;
  assign done = r_done;
  assign err = r_err;
  assign busy = r_busy;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_rr <= '0;
      r_id <= '0;
      r_target <= '0;
      r_ovf <= 1'b0;
      r_grant <= '0;
      r_done <= '0;
      r_err <= 1'b0;
      r_busy <= 1'b0;
      r_clr <= 1'b0;
    end else if (w_abort || r_state == DONE) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_done <= '0;
      r_err <= 1'b0;
      r_busy <= 1'b0;
      r_clr <= 1'b0;
      r_rr <= w_next_rr;
    end else begin
      case (r_state)
        IDLE: if (|req) begin
          r_state <= CLEAR;
          r_id <= w_pick;
          r_target <= w_len ^ (w_len >> 1);
          r_ovf <= 1'b0;
          r_grant <= N_REQ'(1) << w_pick;
          r_clr <= 1'b1;
          r_busy <= 1'b1;
        end
        CLEAR: begin
          r_state <= RUN;
          r_clr <= 1'b0;
        end
        RUN: begin
          r_ovf <= r_ovf | cnt_overflow;
          if (w_match) begin
            r_state <= DONE;
            r_done <= r_grant;
            r_err <= r_ovf | cnt_overflow;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gray_cnt_sched.sv
// tb_gray_cnt_sched: directed bench with an interval-level reference model and a
// behavioural Gray counter standing in for the shared counter.
module tb_gray_cnt_sched;
  localparam int N = 4;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] len = '0;
  logic pause = 1'b0;
  logic [N-1:0] grant, done;
  logic err, busy, cnt_en, cnt_clr, cnt_overflow;
  logic [W-1:0] cnt_count;
  logic [W-1:0] b = '0;
  logic force_ovf = 1'b0;
  logic mon = 1'b0;
  int errors = 0;
  int checks = 0;
  int n;
  logic [7:0] gseq [6] = '{8'h00, 8'h01, 8'h03, 8'h02, 8'h06, 8'h07};

  always #5 clk = ~clk;

  assign cnt_count = b ^ (b >> 1);
  assign cnt_overflow = force_ovf | (cnt_en && b == 8'hFF);
  always @(posedge clk) b <= cnt_clr ? '0 : cnt_en ? b + 8'd1 : b;

  gray_cnt_sched #(.N_REQ(N), .CW(W)) dut (
    .clk(clk), .rst(rst), .req(req), .len(len), .pause(pause),
    .grant(grant), .done(done), .err(err), .busy(busy),
    .cnt_en(cnt_en), .cnt_clr(cnt_clr),
    .cnt_count(cnt_count), .cnt_overflow(cnt_overflow)
  );

  // Reference: owner, cycles since grant, counter advances so far, requested length.
  int m_owner = -1;
  int m_ptr = 0;
  int m_age = 0;
  int m_steps = 0;
  int m_len = 0;
  int m_p;
  bit m_ovf = 1'b0;
  bit m_fin = 1'b0;
  logic [1:0] m_o2;
  logic [N-1:0] e_grant, e_done;
  logic e_err, e_busy, e_clr, e_en, e_cvalid;
  logic [W-1:0] e_count;

  function automatic int pick(logic [N-1:0] r, int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  always_comb m_p = pick(req, m_ptr);
  assign m_o2 = m_owner[1:0];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner <= -1;
      m_ptr <= 0;
      m_fin <= 1'b0;
    end else if (m_owner < 0) begin
      if (|req) begin
        m_owner <= m_p;
        m_age <= 0;
        m_steps <= 0;
        m_len <= int'(len[m_p*W +: W]);
        m_ovf <= 1'b0;
        m_fin <= 1'b0;
      end
    end else if (m_fin || !req[m_o2]) begin
      m_owner <= -1;
      m_ptr <= (m_owner + 1) % N;
      m_fin <= 1'b0;
    end else begin
      m_age <= m_age + 1;
      if (m_age >= 1) begin
        m_ovf <= m_ovf | cnt_overflow;
        if (m_steps == m_len) m_fin <= 1'b1;
        else if (!pause) m_steps <= m_steps + 1;
      end
    end
  end

  always_comb begin
    e_busy = m_owner >= 0;
    e_grant = e_busy ? N'(1) << m_o2 : '0;
    e_done = m_fin ? e_grant : '0;
    e_err = m_fin && m_ovf;
    e_clr = e_busy && m_age == 0;
    e_cvalid = e_busy && m_age >= 1;
    e_en = e_cvalid && !m_fin && req[m_o2] && !pause && m_steps != m_len;
    e_count = W'(m_steps) ^ (W'(m_steps) >> 1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && mon) begin
      chk("grant", grant, e_grant);
      chk("done", done, e_done);
      chk("err", err, e_err);
      chk("busy", busy, e_busy);
      chk("cnt_clr", cnt_clr, e_clr);
      chk("cnt_en", cnt_en, e_en);
      if (e_cvalid) chk("count", cnt_count, e_count);
    end
  end

  task automatic tick(input int k = 1);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int id, input int maxc, output int c);
    c = 0;
    while (done[id] !== 1'b1 && c < maxc) begin
      tick();
      c++;
    end
    chk("done_seen", done[id], 1);
  endtask

  task automatic wait_grant(input int maxc);
    int c;
    c = 0;
    while (grant === '0 && c < maxc) begin
      tick();
      c++;
    end
    chk("grant_seen", 32'(grant != '0), 1);
  endtask

  initial begin
    tick(2);
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_en", cnt_en, 0);
    chk("rst_clr", cnt_clr, 0);
    rst = 1'b0;
    mon = 1'b1;
    tick();
    req = 4'b0001;
    len[0 +: 8] = 8'd5;
    tick();
    chk("t1_grant", grant, 4'b0001);
    chk("t1_clr", cnt_clr, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t1_count", cnt_count, gseq[i]);
      chk("t1_clr_low", cnt_clr, 0);
    end
    tick();
    chk("t1_done", done, 4'b0001);
    chk("t1_err", err, 0);
    chk("t1_hold", cnt_count, 8'h07);
    req = '0;
    tick();
    chk("t1_gap_en", cnt_en, 0);
    chk("t1_gap_clr", cnt_clr, 0);
    chk("t1_gap_busy", busy, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1111;
    len = {8'd2, 8'd0, 8'd1, 8'd3};
    for (int i = 0; i < 4; i++) begin
      wait_grant(20);
      chk("t2_grant_order", grant, 32'(1) << i);
      wait_done(i, 20, n);
      chk("t2_done_order", done, 32'(1) << i);
      req[i] = 1'b0;
      tick();
    end
    req = 4'b0011;
    wait_grant(20);
    chk("t2_wrap", grant, 4'b0001);
    wait_done(0, 20, n);
    req = '0;
    tick();
    len[0 +: 8] = 8'd0;
    req = 4'b0001;
    tick();
    chk("t3_len0_grant", grant, 4'b0001);
    tick(2);
    chk("t3_len0_done", done, 4'b0001);
    chk("t3_len0_count", cnt_count, 8'h00);
    req = '0;
    tick();
    len[16 +: 8] = 8'd255;
    req = 4'b0100;
    wait_done(2, 300, n);
    chk("t3_len255_lat", n, 258);
    chk("t3_len255_count", cnt_count, 8'h80);
    chk("t3_len255_err", err, 0);
    req = '0;
    tick();
    len[24 +: 8] = 8'd4;
    req = 4'b1000;
    tick(3);
    chk("t4_count_pre", cnt_count, 8'h01);
    pause = 1'b1;
    #1;
    chk("t4_en_paused", cnt_en, 0);
    tick();
    chk("t4_frozen1", cnt_count, 8'h01);
    tick();
    chk("t4_frozen2", cnt_count, 8'h01);
    chk("t4_en_paused2", cnt_en, 0);
    tick();
    pause = 1'b0;
    wait_done(3, 20, n);
    chk("t4_lat", n, 4);
    req = '0;
    tick();
    len[8 +: 8] = 8'd10;
    req = 4'b0010;
    tick(4);
    req = '0;
    #1;
    chk("t5_abort_en", cnt_en, 0);
    tick();
    chk("t5_abort_grant", grant, 0);
    chk("t5_abort_busy", busy, 0);
    chk("t5_abort_done", done, 0);
    len[16 +: 8] = 8'd1;
    req = 4'b1101;
    tick();
    chk("t5_rr_next", grant, 4'b0100);
    wait_done(2, 20, n);
    req = '0;
    tick();
    len[0 +: 8] = 8'd20;
    req = 4'b0001;
    tick(5);
    chk("t6_running", cnt_en, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_grant", grant, 0);
    chk("t6_rst_en", cnt_en, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    req = '0;
    tick();
    rst = 1'b0;
    tick();
    len[0 +: 8] = 8'd6;
    req = 4'b0001;
    tick(4);
    force_ovf = 1'b1;
    tick();
    force_ovf = 1'b0;
    wait_done(0, 20, n);
    chk("t7_err", err, 1);
    req = '0;
    tick();
    len[0 +: 8] = 8'd2;
    req = 4'b0001;
    wait_done(0, 20, n);
    chk("t7_err_next", err, 0);
    req = '0;
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
